// File: rtl/niosbase_ocimem_pkg.sv
// Shared constants for the Nios II OCIMEM debug-memory arbiter: FSM encodings,
// jdo field positions and the default RAM geometry.
package niosbase_ocimem_pkg;

   localparam int OCIMEM_ADDR_W = 8;

   // jdo field positions as laid out by the sysclk debug slave
   localparam int JDO_ADDR_LSB   = 25;
   localparam int JDO_RW_BIT     = 34;
   localparam int JDO_ERRCLR_BIT = 35;
   localparam int JDO_DATA_LSB   = 3;

   typedef logic [2:0] ocimem_state_t;

   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_CPU_ACC    = 3'd1;
   localparam logic [2:0] ST_CPU_ACK    = 3'd2;
   localparam logic [2:0] ST_JTAG_RD    = 3'd3;
   localparam logic [2:0] ST_JTAG_RDATA = 3'd4;
   localparam logic [2:0] ST_JTAG_WR    = 3'd5;

endpackage

// File: rtl/niosbase_ocimem_ram.sv
// Single-port synchronous RAM with byte enables and 1-cycle read latency.
// Optional per-byte even parity when NIOSBASE_OCIMEM_PARITY_EN is defined.
module niosbase_ocimem_ram #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic [ADDR_W-1:0]     addr_i,
   input  logic                  we_i,
   input  logic [DATA_W/8-1:0]   be_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o,
   output logic                  parity_err_o
);

   localparam int NB = DATA_W / 8;

`ifdef NIOSBASE_OCIMEM_PARITY_EN
   // Word layout: {parity[NB-1:0], data[DATA_W-1:0]}
   logic [DATA_W+NB-1:0] mem_q [2**ADDR_W];
   logic [DATA_W+NB-1:0] rword_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (be_i[b]) begin
               mem_q[addr_i][b*8 +: 8]   <= wdata_i[b*8 +: 8];
               mem_q[addr_i][DATA_W + b] <= ^wdata_i[b*8 +: 8];
            end
         end
      end
      rword_q <= mem_q[addr_i];
   end

   assign rdata_o = rword_q[DATA_W-1:0];

   always_comb begin
      parity_err_o = 1'b0;
      for (int b = 0; b < NB; b++) begin
         if (rword_q[DATA_W + b] != ^rword_q[b*8 +: 8]) parity_err_o = 1'b1;
      end
   end
`else
   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         for (int b = 0; b < NB; b++) begin
            if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o      = rdata_q;
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: rtl/niosbase_ocimem_arbiter.sv
// OCIMEM controller: arbitrates one debug RAM between the JTAG strobes and the
// CPU Avalon slave. Optional parity checking via NIOSBASE_OCIMEM_PARITY_EN.
module niosbase_ocimem_arbiter
   import niosbase_ocimem_pkg::*;
#(
   parameter int ADDR_W = OCIMEM_ADDR_W,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [37:0]           jdo,
   input  logic                  take_action_ocimem_a,
   input  logic                  take_action_ocimem_b,
   input  logic                  take_no_action_ocimem_a,
   input  logic [ADDR_W-1:0]     avs_address,
   input  logic                  avs_read,
   input  logic                  avs_write,
   input  logic [DATA_W-1:0]     avs_writedata,
   input  logic [DATA_W/8-1:0]   avs_byteenable,
   output logic [DATA_W-1:0]     avs_readdata,
   output logic                  avs_waitrequest,
   output logic [DATA_W-1:0]     MonDReg,
   output logic                  monitor_ready,
   output logic                  monitor_error,
   output logic [2:0]            dbg_state_o,
   output logic [ADDR_W-1:0]     dbg_mon_areg_o
);

   ocimem_state_t       state_q, state_d;
   logic [ADDR_W-1:0]   mon_areg_q, mon_areg_d;
   logic [DATA_W-1:0]   mon_dreg_q, mon_dreg_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                pend_q, pend_d;
   logic                op_wr_q, op_wr_d;
   logic                last_cpu_q, last_cpu_d;
   logic                ready_q, ready_d;
   logic                error_q, error_d;
   logic                addr_only_q, addr_only_d;

   logic                ram_we;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W/8-1:0] ram_be;
   logic [DATA_W-1:0]   ram_wdata;
   logic [DATA_W-1:0]   ram_rdata;
   logic                ram_perr;

   logic strobe_any, accept, queue_rd, cpu_req;
   logic unused_jdo;

   assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
   assign strobe_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
   assign accept     = strobe_any & ~pend_q;
   assign queue_rd   = (take_action_ocimem_a & jdo[JDO_RW_BIT]) | take_no_action_ocimem_a;
   assign cpu_req    = avs_read | avs_write;

   always_comb begin
      state_d     = state_q;
      mon_areg_d  = mon_areg_q;
      mon_dreg_d  = mon_dreg_q;
      wdata_d     = wdata_q;
      pend_d      = pend_q;
      op_wr_d     = op_wr_q;
      last_cpu_d  = last_cpu_q;
      ready_d     = ready_q;
      error_d     = error_q;
      addr_only_d = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = mon_areg_q;
      ram_be      = '1;
      ram_wdata   = wdata_q;

      if (addr_only_q) ready_d = 1'b1;

      if (take_action_ocimem_a && jdo[JDO_ERRCLR_BIT]) error_d = 1'b0;

      // Strobes are only accepted with no JTAG operation outstanding
      if (strobe_any && pend_q) begin
         error_d = 1'b1;
      end else if (accept) begin
         ready_d = 1'b0;
         if (take_action_ocimem_a) mon_areg_d = jdo[JDO_ADDR_LSB +: ADDR_W];
         if (take_action_ocimem_b) begin
            pend_d  = 1'b1;
            op_wr_d = 1'b1;
            wdata_d = jdo[JDO_DATA_LSB +: DATA_W];
         end else if (queue_rd) begin
            pend_d  = 1'b1;
            op_wr_d = 1'b0;
         end else begin
            addr_only_d = 1'b1;
         end
      end

      case (state_q)
         ST_IDLE: begin
            // pend_d lets a fresh strobe win the grant in its own cycle
            if (pend_d && (last_cpu_q || !cpu_req)) begin
               state_d = op_wr_d ? ST_JTAG_WR : ST_JTAG_RD;
            end else if (cpu_req) begin
               state_d = ST_CPU_ACC;
            end
         end
         ST_CPU_ACC: begin
            ram_addr  = avs_address;
            ram_we    = avs_write;
            ram_be    = avs_byteenable;
            ram_wdata = avs_writedata;
            state_d   = ST_CPU_ACK;
         end
         ST_CPU_ACK: begin
            last_cpu_d = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_JTAG_RD: begin
            state_d = ST_JTAG_RDATA;
         end
         ST_JTAG_RDATA: begin
            mon_dreg_d = ram_rdata;
            ready_d    = 1'b1;
            pend_d     = 1'b0;
            last_cpu_d = 1'b0;
            mon_areg_d = mon_areg_q + ADDR_W'(1);
            if (ram_perr) error_d = 1'b1;
            state_d    = ST_IDLE;
         end
         ST_JTAG_WR: begin
            ram_we     = 1'b1;
            mon_dreg_d = wdata_q;
            ready_d    = 1'b1;
            pend_d     = 1'b0;
            last_cpu_d = 1'b0;
            mon_areg_d = mon_areg_q + ADDR_W'(1);
            state_d    = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         mon_areg_q  <= '0;
         mon_dreg_q  <= '0;
         wdata_q     <= '0;
         pend_q      <= 1'b0;
         op_wr_q     <= 1'b0;
         last_cpu_q  <= 1'b0;
         ready_q     <= 1'b1;
         error_q     <= 1'b0;
         addr_only_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mon_areg_q  <= mon_areg_d;
         mon_dreg_q  <= mon_dreg_d;
         wdata_q     <= wdata_d;
         pend_q      <= pend_d;
         op_wr_q     <= op_wr_d;
         last_cpu_q  <= last_cpu_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         addr_only_q <= addr_only_d;
      end
   end

   niosbase_ocimem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_ram (
      .clk          (clk),
      .addr_i       (ram_addr),
      .we_i         (ram_we),
      .be_i         (ram_be),
      .wdata_i      (ram_wdata),
      .rdata_o      (ram_rdata),
      .parity_err_o (ram_perr)
   );

   assign avs_waitrequest = (state_q != ST_CPU_ACK);
   assign avs_readdata    = (state_q == ST_CPU_ACK) ? ram_rdata : '0;
   assign MonDReg         = mon_dreg_q;
   assign monitor_ready   = ready_q;
   assign monitor_error   = error_q;
   assign dbg_state_o     = state_q;
   assign dbg_mon_areg_o  = mon_areg_q;

endmodule

// File: tb/tb_niosbase_ocimem_arbiter.sv
// Directed bench for niosbase_ocimem_arbiter; define NIOSBASE_OCIMEM_PARITY_EN
// to add the parity bit-flip step.
module tb_niosbase_ocimem_arbiter;
   import niosbase_ocimem_pkg::*;

   logic        clk;
   logic        reset_n;
   logic [37:0] jdo;
   logic        take_action_ocimem_a;
   logic        take_action_ocimem_b;
   logic        take_no_action_ocimem_a;
   logic [7:0]  avs_address;
   logic        avs_read;
   logic        avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [31:0] MonDReg;
   logic        monitor_ready;
   logic        monitor_error;
   logic [2:0]  dbg_state_o;
   logic [7:0]  dbg_mon_areg_o;

   int n_checks = 0;
   int n_pass   = 0;

   niosbase_ocimem_arbiter dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_byteenable          (avs_byteenable),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .dbg_state_o             (dbg_state_o),
      .dbg_mon_areg_o          (dbg_mon_areg_o)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic ec);
      logic [37:0] j;
      j        = '0;
      j[32:25] = a;
      j[34]    = rd;
      j[35]    = ec;
      return j;
   endfunction

   function automatic logic [37:0] jdo_d(input logic [31:0] d);
      logic [37:0] j;
      j       = '0;
      j[34:3] = d;
      return j;
   endfunction

   // driver tasks: each strobe is one cycle wide; returns in cycle N+1
   task automatic jtag_strobe(input int kind, input logic [37:0] j);
      jdo = j;
      take_action_ocimem_a    = (kind == 0);
      take_action_ocimem_b    = (kind == 1);
      take_no_action_ocimem_a = (kind == 2);
      tick();
      take_action_ocimem_a    = 1'b0;
      take_action_ocimem_b    = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic wait_ready(output int cyc);
      cyc = 1;
      while (!monitor_ready && cyc < 20) begin
         tick();
         cyc++;
      end
   endtask

   task automatic cpu_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             output logic [31:0] rdata, output int lat);
      avs_address    = a;
      avs_writedata  = d;
      avs_byteenable = be;
      avs_read       = rd;
      avs_write      = wr;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (avs_waitrequest && lat < 20);
      rdata     = avs_readdata;
      avs_read  = 1'b0;
      avs_write = 1'b0;
   endtask

   initial begin
      logic [31:0] rd;
      int lat, cyc, acks;
      logic [31:0] ack_data;

      reset_n = 1'b0;
      jdo = '0;
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      avs_address = '0;
      avs_read = 1'b0;
      avs_write = 1'b0;
      avs_writedata = '0;
      avs_byteenable = '0;
      tick();
      tick();

      chk("rst_state", dbg_state_o, ST_IDLE);
      chk("rst_ready", monitor_ready, 1'b1);
      chk("rst_error", monitor_error, 1'b0);
      chk("rst_waitreq", avs_waitrequest, 1'b1);
      chk("rst_readdata", avs_readdata, 32'h0);
      chk("rst_mondreg", MonDReg, 32'h0);
      chk("rst_areg", dbg_mon_areg_o, 8'h00);
      reset_n = 1'b1;
      tick();

      // JTAG write then read at 0x10
      jtag_strobe(0, jdo_a(8'h10, 1'b0, 1'b0));
      chk("aload_ready_low", monitor_ready, 1'b0);
      tick();
      chk("aload_ready_high", monitor_ready, 1'b1);
      chk("aload_areg", dbg_mon_areg_o, 8'h10);
      jtag_strobe(1, jdo_d(32'hDEADBEEF));
      chk("jwr_state", dbg_state_o, ST_JTAG_WR);
      tick();
      chk("jwr_ready", monitor_ready, 1'b1);
      chk("jwr_mondreg", MonDReg, 32'hDEADBEEF);
      chk("jwr_areg", dbg_mon_areg_o, 8'h11);
      jtag_strobe(0, jdo_a(8'h10, 1'b0, 1'b0));
      tick();
      jtag_strobe(2, '0);
      tick();
      chk("jrd_ready_n2", monitor_ready, 1'b0);
      tick();
      chk("jrd_ready_n3", monitor_ready, 1'b1);
      chk("jrd_mondreg", MonDReg, 32'hDEADBEEF);
      chk("jrd_areg", dbg_mon_areg_o, 8'h11);

      // CPU byte-enabled write over a full word, then read back
      cpu_access(1'b0, 1'b1, 8'h20, 32'hFFFFFFFF, 4'hF, rd, lat);
      chk("cpu_wr1_lat", lat, 2);
      tick();
      cpu_access(1'b0, 1'b1, 8'h20, 32'h12345678, 4'b0011, rd, lat);
      chk("cpu_wr2_lat", lat, 2);
      tick();
      cpu_access(1'b1, 1'b0, 8'h20, 32'h0, 4'hF, rd, lat);
      chk("cpu_rd_lat", lat, 2);
      chk("cpu_rd_data", rd, 32'hFFFF5678);
      chk("cpu_idle_readdata", avs_waitrequest, 1'b0);
      tick();
      chk("cpu_after_waitreq", avs_waitrequest, 1'b1);

      // read+write together behaves as a write
      cpu_access(1'b1, 1'b1, 8'h30, 32'h00000055, 4'hF, rd, lat);
      tick();
      cpu_access(1'b1, 1'b0, 8'h30, 32'h0, 4'hF, rd, lat);
      chk("cpu_rw_as_write", rd, 32'h00000055);
      tick();

      // contention: continuous CPU reads of 0x10 while a JTAG read is strobed
      jtag_strobe(0, jdo_a(8'h10, 1'b0, 1'b0));
      tick();
      avs_address    = 8'h10;
      avs_byteenable = 4'hF;
      avs_read       = 1'b1;
      tick();
      chk("cont_cpu_acc", dbg_state_o, ST_CPU_ACC);
      jtag_strobe(2, '0);
      cyc = 1;
      acks = 0;
      ack_data = '0;
      while (!monitor_ready && cyc < 20) begin
         if (!avs_waitrequest) begin
            acks++;
            ack_data = avs_readdata;
         end
         tick();
         cyc++;
      end
      chk("cont_jtag_within5", (cyc <= 5), 1'b1);
      chk("cont_jtag_data", MonDReg, 32'hDEADBEEF);
      chk("cont_cpu_acks", acks, 1);
      chk("cont_cpu_data1", ack_data, 32'hDEADBEEF);
      cyc = 0;
      while (avs_waitrequest && cyc < 20) begin
         tick();
         cyc++;
      end
      chk("cont_cpu_regrant", (cyc <= 3), 1'b1);
      chk("cont_cpu_data2", avs_readdata, 32'hDEADBEEF);
      avs_read = 1'b0;
      tick();

      // address wrap 255 -> 0
      jtag_strobe(0, jdo_a(8'hFF, 1'b0, 1'b0));
      tick();
      jtag_strobe(1, jdo_d(32'hA5A50001));
      tick();
      chk("wrap_areg0", dbg_mon_areg_o, 8'h00);
      jtag_strobe(1, jdo_d(32'h0BADF00D));
      tick();
      chk("wrap_areg1", dbg_mon_areg_o, 8'h01);
      cpu_access(1'b1, 1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
      chk("wrap_word0", rd, 32'h0BADF00D);
      tick();
      cpu_access(1'b1, 1'b0, 8'hFF, 32'h0, 4'hF, rd, lat);
      chk("wrap_word255", rd, 32'hA5A50001);
      tick();

      // double strobe on consecutive cycles
      jtag_strobe(0, jdo_a(8'h40, 1'b0, 1'b0));
      tick();
      take_no_action_ocimem_a = 1'b1;
      tick();
      tick();
      take_no_action_ocimem_a = 1'b0;
      wait_ready(cyc);
      chk("dbl_ready", monitor_ready, 1'b1);
      chk("dbl_error", monitor_error, 1'b1);
      tick();
      tick();
      chk("dbl_one_read", dbg_mon_areg_o, 8'h41);
      chk("dbl_error_sticky", monitor_error, 1'b1);
      jtag_strobe(0, jdo_a(8'h40, 1'b0, 1'b1));
      chk("err_clear", monitor_error, 1'b0);
      tick();

      // reset while in JTAG_RD
      jtag_strobe(2, '0);
      chk("rstmid_in_rd", dbg_state_o, ST_JTAG_RD);
      reset_n = 1'b0;
      tick();
      chk("rstmid_state", dbg_state_o, ST_IDLE);
      chk("rstmid_ready", monitor_ready, 1'b1);
      chk("rstmid_waitreq", avs_waitrequest, 1'b1);
      chk("rstmid_areg", dbg_mon_areg_o, 8'h00);
      reset_n = 1'b1;
      tick();
      cpu_access(1'b1, 1'b0, 8'h00, 32'h0, 4'hF, rd, lat);
      chk("rstmid_cpu_lat", lat, 2);
      chk("rstmid_cpu_data", rd, 32'h0BADF00D);
      tick();

`ifdef NIOSBASE_OCIMEM_PARITY_EN
      jtag_strobe(0, jdo_a(8'h05, 1'b0, 1'b0));
      tick();
      jtag_strobe(1, jdo_d(32'h000000FF));
      tick();
      dut.u_ram.mem_q[5][0] = ~dut.u_ram.mem_q[5][0];
      jtag_strobe(0, jdo_a(8'h05, 1'b0, 1'b0));
      tick();
      chk("par_error_before", monitor_error, 1'b0);
      jtag_strobe(2, '0);
      wait_ready(cyc);
      chk("par_error", monitor_error, 1'b1);
      chk("par_mondreg", MonDReg, 32'h000000FE);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/niosbase_ocimem_arbiter.md
# niosbase_ocimem_arbiter

Controller and arbiter for the Nios II on-chip debug memory (OCIMEM). It shares one single-port 256×32 RAM between two requesters: the JTAG debug path, driven by `take_*_ocimem_*` strobes and `jdo` from the debug slave, and the CPU `debug_mem_slave` Avalon port. It also owns `MonDReg`, `monitor_ready` and `monitor_error`, which feed back into the JTAG scan chain.

## Interface
Parameters:
- ADDR_W, 8: RAM word-address width (256 words).
- DATA_W, 32: RAM data width.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- jdo  in  38  JTAG data latched by the sysclk debug slave.
- take_action_ocimem_a  in  1  single-cycle strobe: load address.
- take_action_ocimem_b  in  1  single-cycle strobe: write word.
- take_no_action_ocimem_a  in  1  single-cycle strobe: read word.
- avs_address  in  ADDR_W  CPU word address.
- avs_read / avs_write  in  1  CPU request. Held until `avs_waitrequest` is low.
- avs_writedata  in  DATA_W  CPU write data.
- avs_byteenable  in  4  CPU byte enables.
- avs_readdata  out  DATA_W  CPU read data, valid when `avs_read` is high and `avs_waitrequest` is low.
- avs_waitrequest  out  1  CPU stall.
- MonDReg  out  32  JTAG monitor data register.
- monitor_ready  out  1  last JTAG access complete.
- monitor_error  out  1  sticky JTAG error.

## Operation
- **JTAG address register MonAReg[ADDR_W-1:0]**
  - take_action_ocimem_a: MonAReg ← jdo[ADDR_W+24:25]. When jdo[34]=1 this also queues a read.
  - take_action_ocimem_b: queues a write of jdo[34:3].
  - take_no_action_ocimem_a: queues a read.
  - Every completed JTAG read or write post-increments MonAReg, wrapping 255→0.
- **Pending latch**
  - Each strobe sets `jtag_pend` and captures the operation type and data.
  - A strobe arriving while `jtag_pend` is already set is dropped and sets `monitor_error`.
  - Any accepted strobe clears `monitor_ready`.
- **FSM states:** IDLE, CPU_ACC, CPU_ACK, JTAG_RD, JTAG_RDATA, JTAG_WR.
  - IDLE:
    - If `jtag_pend` is set and `last_cpu`=1, or the CPU is not requesting: go to JTAG_RD or JTAG_WR.
    - Otherwise, if the CPU is requesting: go to CPU_ACC.
    - This alternates grants when both sides contend.
  - CPU_ACC: issue the RAM read, or the write with byte enables. Go to CPU_ACK.
  - CPU_ACK: drive `avs_waitrequest`=0 and `avs_readdata` from RAM q. Set `last_cpu`=1. Return to IDLE.
  - JTAG_RD: issue the RAM read at MonAReg. Go to JTAG_RDATA.
  - JTAG_RDATA: MonDReg ← q, `monitor_ready` ← 1, clear `jtag_pend`, `last_cpu` ← 0, increment MonAReg. Return to IDLE.
  - JTAG_WR: write all bytes, MonDReg ← write data, `monitor_ready` ← 1, clear `jtag_pend`, `last_cpu` ← 0, increment MonAReg. Return to IDLE.
- A JTAG address-only load (jdo[34]=0) does not queue an access: `monitor_ready` is set on the next cycle.
- `monitor_error` clears only on take_action_ocimem_a with jdo[35]=1.
- A CPU request with both `avs_read` and `avs_write` high is treated as a write.

## Timing
- Reset values: state IDLE, MonAReg 0, MonDReg 0, `jtag_pend` 0, `last_cpu` 0, `monitor_ready` 1, `monitor_error` 0, `avs_waitrequest` 1, `avs_readdata` 0. RAM contents are not reset.
- `avs_waitrequest` is low only in CPU_ACK.
- CPU access latency, uncontended: request in cycle N, `avs_waitrequest` low in N+2.
- JTAG access latency: strobe in cycle N, `monitor_ready` high in N+3, extended by up to 2 cycles if a CPU access is in flight.
- RAM: synchronous read, 1-cycle latency, write takes effect at the clock edge.
- Reset mid-access: the access is abandoned, the pending JTAG operation is lost, and the RAM may hold a completed write.

## Configuration
- `NIOSBASE_OCIMEM_PARITY_EN` defined:
  - The RAM stores one even-parity bit per byte (36 bits per word).
  - A JTAG read with a parity mismatch sets `monitor_error`; MonDReg still loads the data.
  - A CPU read mismatch is ignored.
- Undefined: no parity storage and no parity checking.

## Structure
- Package `niosbase_ocimem_pkg`:
  - state enum;
  - the jdo field-position constants (addr LSB 25, rw bit 34, error-clear bit 35, data LSB 3);
  - the default ADDR_W.
- Sub-module `niosbase_ocimem_ram`: single-port synchronous RAM with byte enables and optional parity, instantiated once.

## Test plan
- JTAG write then read: take_action_ocimem_a (addr 0x10, jdo[34]=0), take_action_ocimem_b (data 0xDEADBEEF), set addr 0x10, take_no_action_ocimem_a -> MonDReg=0xDEADBEEF, `monitor_ready`=1, MonAReg=0x11.
- CPU write to 0x20 with byteenable 4'b0011 and data 0x12345678 over prior 0xFFFFFFFF, then CPU read -> `avs_readdata`=0xFFFF5678, `avs_waitrequest` low exactly 2 cycles after each request.
- Contention: CPU read held continuously while a JTAG read is strobed -> grants alternate; the JTAG read completes within 5 cycles of the strobe and the CPU is never starved.
- Wrap-around: JTAG writes at address 255 -> MonAReg=0, and the next write lands in word 0.
- Double strobe: two take_no_action_ocimem_a 1 cycle apart -> `monitor_error`=1, exactly one read performed. take_action_ocimem_a with jdo[35]=1 -> `monitor_error`=0.
- Reset asserted in JTAG_RD -> next cycle: IDLE, `monitor_ready`=1, `avs_waitrequest`=1. With parity enabled: forced RAM bit flip -> JTAG read sets `monitor_error`.
